// File: rtl/dcache_wport_if.sv
// Handshake bundle between the store pipeline / refill unit and the data-RAM write port.
// The master drives requests; the slave is the write-port controller.
interface dcache_wport_if #(
    parameter int IDX_W = 7,
    parameter int WORDS = 8
);
    logic                   refill_start;
    logic [IDX_W-1:0]       refill_index;
    logic                   refill_valid;
    logic                   refill_ready;
    logic [31:0]            refill_data;
    logic                   refill_busy;
    logic                   refill_done;

    logic                   st_valid;
    logic                   st_ready;
    logic [IDX_W-1:0]       st_index;
    logic [2:0]             st_offset;
    logic [3:0]             st_wstrb;
    logic [31:0]            st_wdata;

    logic [4*WORDS-1:0]     ram_wen;
    logic [IDX_W-1:0]       ram_windex;
    logic [32*WORDS-1:0]    ram_wdata;

    modport master (
        output refill_start, refill_index, refill_valid, refill_data,
        output st_valid, st_index, st_offset, st_wstrb, st_wdata,
        input  refill_ready, refill_busy, refill_done, st_ready,
        input  ram_wen, ram_windex, ram_wdata
    );

    modport slave (
        input  refill_start, refill_index, refill_valid, refill_data,
        input  st_valid, st_index, st_offset, st_wstrb, st_wdata,
        output refill_ready, refill_busy, refill_done, st_ready,
        output ram_wen, ram_windex, ram_wdata
    );
endinterface

// File: rtl/dcache_wport_ctrl.sv
// Arbitrates the data-cache way RAM write port between CPU store hits and
// full-line refills assembled from eight 32-bit bus beats.
module dcache_wport_ctrl #(
    parameter int IDX_W = 7,
    parameter int WORDS = 8
) (
    input  logic            clk,
    input  logic            rst,
    dcache_wport_if.slave   bus
);
    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   index_reg;
    logic               done_reg;
    logic [31:0]        line_mem [WORDS];

    logic                   beat_acc;
    logic                   line_wr;
    logic                   busy;
    logic                   st_ready;
    logic                   st_acc;
    logic [4*WORDS-1:0]     st_wen;
    logic [32*WORDS-1:0]    line_word;
    logic [4*WORDS-1:0]     wen_next;
    logic [IDX_W-1:0]       windex_next;
    logic [32*WORDS-1:0]    wdata_next;

    assign busy     = (state_reg != IDLE);
    assign line_wr  = (state_reg == WRITE);
    assign beat_acc = (state_reg == FILL) && bus.refill_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            index_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.refill_start) begin
                        state_reg <= FILL;
                        index_reg <= bus.refill_index;
                        cnt_reg   <= '0;
                    end
                end
                FILL: begin
                    if (bus.refill_valid) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(WORDS - 1))
                            state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Line buffer has no reset: a partial line is simply never written out.
    always_ff @(posedge clk) begin
        if (beat_acc)
            line_mem[cnt_reg] <= bus.refill_data;
    end

    // Blocking same-set stores for all of FILL and WRITE keeps a store from
    // being clobbered by the stale line that is about to land.
    assign st_ready = !rst && !line_wr && !(busy && (bus.st_index == index_reg));
    assign st_acc   = bus.st_valid && st_ready;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign st_wen[4*gi +: 4]     = (bus.st_offset == 3'(gi)) ? bus.st_wstrb : 4'b0000;
            assign line_word[32*gi +: 32] = line_mem[gi];
        end
    endgenerate

    always_comb begin
        wen_next    = '0;
        windex_next = '0;
        wdata_next  = '0;
        if (line_wr) begin
            wen_next    = '1;
            windex_next = index_reg;
            wdata_next  = line_word;
        end else if (st_acc) begin
            wen_next    = st_wen;
            windex_next = bus.st_index;
            wdata_next  = {WORDS{bus.st_wdata}};
        end
    end

    assign bus.refill_ready = (state_reg == FILL);
    assign bus.refill_busy  = busy;
    assign bus.refill_done  = done_reg;
    assign bus.st_ready     = st_ready;
    assign bus.ram_wen      = wen_next;
    assign bus.ram_windex   = windex_next;
    assign bus.ram_wdata    = wdata_next;
endmodule
